// File: rtl/data_mem_pkg.sv
// Shared types and lane helpers for the load/store data memory.
// Covers byte-enable generation, store-data replication and load extraction/extension.
package data_mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    // Size 11 is never legal, so it is reported the same way as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = off[0];
            MEM_W:   bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            MEM_B:   be = 4'b0001 << off;
            MEM_H:   be = 4'b0011 << off;
            MEM_W:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] wd;
        case (size)
            MEM_B:   wd = {4{wdata[7:0]}};
            MEM_H:   wd = {2{wdata[15:0]}};
            default: wd = wdata;
        endcase
        return wd;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            MEM_B:   res = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            MEM_H:   res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_mem_bram.sv
// Single-port byte-enable block RAM with registered read data.
// The array itself is never reset; contents survive core resets.
module data_mem_bram #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            wen,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] rdata_q;

    // Read-before-write: rdata_q only changes on an enabled access, so it holds
    // the captured word for as long as the response is pending.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_lsu.sv
// Handshaked load/store unit front-end for the RV32 data memory.
// One outstanding access at a time; response held until the consumer accepts it.
module data_mem_lsu
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 1,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic        err_q, err_d;

    logic        accept;
    logic        req_err;
    logic [3:0]  ram_wen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    assign accept    = req_valid && req_ready_q;
    assign req_err   = is_misaligned(req_size, req_addr[1:0]);
    assign ram_wen   = (accept && req_we && !req_err) ? byte_enable(req_size, req_addr[1:0]) : 4'b0000;
    assign ram_wdata = store_align(req_size, req_wdata);

    data_mem_bram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_bram (
        .clk   (clk),
        .en    (accept),
        .wen   (ram_wen),
        .addr  (req_addr[ADDR_WIDTH+1:2]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // RESP spends its first cycle loading the output registers from the RAM word,
    // which puts rsp_valid exactly LATENCY edges after acceptance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        size_d      = size_q;
        off_d       = off_q;
        uns_d       = uns_q;
        we_d        = we_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d      = req_size;
                    off_d       = req_addr[1:0];
                    uns_d       = req_unsigned;
                    we_d        = req_we;
                    err_d       = req_err;
                    req_ready_d = 1'b0;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (err_q || we_q) ? 32'h0 : load_extract(ram_rdata, size_q, off_q, uns_q);
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'h0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            size_q      <= size_d;
            off_q       <= off_d;
            uns_q       <= uns_d;
            we_q        <= we_d;
            err_q       <= err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: the driver queues expected responses,
// a negedge monitor pops and compares them on every response handshake.
module tb_data_mem_lsu;

    localparam int AW  = 12;
    localparam int LAT = 3;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW+1:0] req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_id = 0;
    logic prev_valid = 1'b0;

    data_mem_lsu #(
        .ADDR_WIDTH (AW),
        .LATENCY    (LAT),
        .INIT_FILE  ("")
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: latency check on the rising edge of rsp_valid, data check on handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid && !prev_valid) begin
                if (sb_q.size() == 0)
                    checkOutput("unexpected rsp_valid", {31'b0, rsp_valid}, 32'd0);
                else
                    checkOutput($sformatf("latency #%0d", sb_q[0].id), cyc - sb_q[0].acc, LAT);
            end
            if (rsp_valid && rsp_ready && sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput($sformatf("rdata #%0d", e.id), rsp_rdata, e.rdata);
                checkOutput($sformatf("err #%0d", e.id), {31'b0, rsp_err}, {31'b0, e.err});
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic applyStimulus(input logic we, input logic [AW+1:0] addr, input logic [1:0] size,
                                 input logic uns, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err, input bit expect_rsp);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput("req_ready timeout", {31'b0, req_ready}, 32'd1);
            return;
        end
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        if (expect_rsp) sb_q.push_back('{exp_rdata, exp_err, cyc + 1, next_id});
        next_id++;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_addr     = (AW+2)'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
    endtask

    task automatic waitDrain();
        int w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb_q.size() != 0) begin
            checkOutput("drain timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = SZ_W;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b1;
        rst_n        = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset rsp_err", {31'b0, rsp_err}, 32'd0);
        rst_n = 1'b1;

        // Word round trip
        applyStimulus(1, 14'h010, SZ_W, 0, 32'hDEADBEEF, 32'h0, 0, 1);
        applyStimulus(0, 14'h010, SZ_W, 0, 32'h0, 32'hDEADBEEF, 0, 1);

        // Byte lane 3 and sign/zero extension
        applyStimulus(1, 14'h020, SZ_W, 0, 32'h00000000, 32'h0, 0, 1);
        applyStimulus(1, 14'h023, SZ_B, 0, 32'hABCDEF80, 32'h0, 0, 1);
        applyStimulus(0, 14'h020, SZ_W, 0, 32'h0, 32'h80000000, 0, 1);
        applyStimulus(0, 14'h023, SZ_B, 0, 32'h0, 32'hFFFFFF80, 0, 1);
        applyStimulus(0, 14'h023, SZ_B, 1, 32'h0, 32'h00000080, 0, 1);

        // Half lanes
        applyStimulus(1, 14'h030, SZ_W, 0, 32'h11223344, 32'h0, 0, 1);
        applyStimulus(0, 14'h032, SZ_H, 0, 32'h0, 32'h00001122, 0, 1);
        applyStimulus(0, 14'h032, SZ_H, 1, 32'h0, 32'h00001122, 0, 1);
        applyStimulus(1, 14'h030, SZ_H, 0, 32'h5555BEEF, 32'h0, 0, 1);
        applyStimulus(0, 14'h030, SZ_W, 0, 32'h0, 32'h1122BEEF, 0, 1);
        applyStimulus(0, 14'h030, SZ_H, 0, 32'h0, 32'hFFFFBEEF, 0, 1);

        // Misalignment and illegal size
        applyStimulus(1, 14'h040, SZ_W, 0, 32'hCAFEF00D, 32'h0, 0, 1);
        applyStimulus(1, 14'h041, SZ_W, 0, 32'h99999999, 32'h0, 1, 1);
        applyStimulus(0, 14'h040, SZ_W, 0, 32'h0, 32'hCAFEF00D, 0, 1);
        applyStimulus(0, 14'h043, SZ_H, 0, 32'h0, 32'h0, 1, 1);
        applyStimulus(0, 14'h042, SZ_W, 0, 32'h0, 32'h0, 1, 1);
        applyStimulus(0, 14'h040, SZ_X, 0, 32'h0, 32'h0, 1, 1);
        applyStimulus(1, 14'h041, SZ_H, 0, 32'h00007777, 32'h0, 1, 1);
        applyStimulus(0, 14'h041, SZ_B, 0, 32'h0, 32'hFFFFFFF0, 0, 1);
        applyStimulus(0, 14'h042, SZ_B, 1, 32'h0, 32'h000000FE, 0, 1);
        applyStimulus(0, 14'h040, SZ_W, 0, 32'h0, 32'hCAFEF00D, 0, 1);
        waitDrain();

        // Backpressure: response held for 5 cycles with rsp_ready low
        rsp_ready = 1'b0;
        applyStimulus(0, 14'h010, SZ_W, 1, 32'h0, 32'hDEADBEEF, 0, 1);
        w = 0;
        while (!rsp_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("bp rsp_valid arrives", {31'b0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp hold valid %0d", i), {31'b0, rsp_valid}, 32'd1);
            checkOutput($sformatf("bp hold rdata %0d", i), rsp_rdata, 32'hDEADBEEF);
            checkOutput($sformatf("bp hold req_ready %0d", i), {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp req_ready after handshake", {31'b0, req_ready}, 32'd1);
        checkOutput("bp rsp_valid after handshake", {31'b0, rsp_valid}, 32'd0);
        waitDrain();

        // Reset while a store waits: response discarded, write kept
        applyStimulus(1, 14'h050, SZ_W, 0, 32'h12345678, 32'h0, 0, 0);
        @(negedge clk);
        checkOutput("wait req_ready", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("mid-reset req_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 14'h050, SZ_W, 0, 32'h0, 32'h12345678, 0, 1);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
